// File: rtl/hw_lock_ctrl_pkg.sv
// Shared definitions for the lock controller: operation codes, the per-core
// handshake state encoding and a constant-time clog2 helper.
package hw_lock_ctrl_pkg;

  localparam logic OP_ACQUIRE = 1'b1;
  localparam logic OP_RELEASE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } core_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_rr_arb.sv
// Combinational round-robin pick: first asserted candidate at or after ptr,
// scanning upward with wrap-around.
module lock_rr_arb
  import hw_lock_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && cand[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/hw_lock_ctrl.sv
// Shares LOCKS mutexes among CORES requesters over 4-phase req/ack.
// Each core: IDLE -> WAIT (capture) -> DONE (ack) -> IDLE on req low.
module hw_lock_ctrl
  import hw_lock_ctrl_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int LOCKS  = 8,
  parameter int LOCK_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CORES-1:0]        req,
  input  logic [CORES-1:0]        op,
  input  logic [CORES*LOCK_W-1:0] lock_id,
  output logic [CORES-1:0]        ack,
  output logic [CORES-1:0]        err,
  output logic [LOCKS-1:0]        lock_held,
  output logic [2*CORES-1:0]      dbg_state
);

  localparam int CW = clog2(CORES);

  core_state_t       state_q [CORES];
  core_state_t       state_d [CORES];
  logic [CORES-1:0]  cap_op, armed, eligible;
  logic [LOCK_W-1:0] cap_id  [CORES];
  logic [CORES-1:0]  id_valid, id_own, id_other;
  logic [CORES-1:0]  direct_svc, direct_err, svc, svc_err;
  logic [CORES-1:0]  ack_d, err_d;
  logic [CW-1:0]     owner_q [LOCKS];
  logic [CW-1:0]     ptr_q   [LOCKS];
  logic [CW-1:0]     gnt_idx [LOCKS];
  logic [CORES-1:0]  cand    [LOCKS];
  logic [CORES-1:0]  gnt     [LOCKS];
  logic [LOCKS-1:0]  lock_grant, lock_release;

  // A core is looked at only from its second WAIT cycle, so a decision made
  // on the current owner table lands two edges after req is sampled.
  always_comb begin
    eligible = '0;
    id_valid = '0;
    id_own   = '0;
    id_other = '0;
    for (int i = 0; i < CORES; i++) begin
      eligible[i] = (state_q[i] == ST_WAIT) && armed[i];
      for (int k = 0; k < LOCKS; k++) begin
        if (cap_id[i] == LOCK_W'(k)) begin
          id_valid[i] = 1'b1;
          if (lock_held[k]) begin
            if (owner_q[k] == CW'(i)) id_own[i] = 1'b1;
            else                      id_other[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    direct_svc   = '0;
    direct_err   = '0;
    lock_release = '0;
    for (int k = 0; k < LOCKS; k++) cand[k] = '0;
    for (int i = 0; i < CORES; i++) begin
      if (eligible[i]) begin
        if (cap_op[i] == OP_RELEASE) begin
          direct_svc[i] = 1'b1;
          direct_err[i] = !id_own[i];
        end else if (!id_valid[i] || id_own[i]) begin
          direct_svc[i] = 1'b1;
          direct_err[i] = 1'b1;
        end
      end
      for (int k = 0; k < LOCKS; k++) begin
        if (eligible[i] && cap_id[i] == LOCK_W'(k)) begin
          // Only a lock that is free right now is contested; a release in
          // the same cycle is seen by acquirers one edge later.
          if (cap_op[i] == OP_ACQUIRE && !lock_held[k]) cand[k][i] = 1'b1;
          if (cap_op[i] == OP_RELEASE && id_own[i])     lock_release[k] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < LOCKS; k++) begin : g_arb
    lock_rr_arb #(.N(CORES)) u_arb (
      .cand    (cand[k]),
      .ptr     (ptr_q[k]),
      .gnt     (gnt[k]),
      .gnt_idx (gnt_idx[k])
    );
    assign lock_grant[k] = |gnt[k];
  end

  always_comb begin
    svc     = direct_svc;
    svc_err = direct_err;
    for (int k = 0; k < LOCKS; k++) svc = svc | gnt[k];
  end

  always_comb begin
    for (int i = 0; i < CORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: if (req[i])  state_d[i] = ST_WAIT;
        ST_WAIT: if (svc[i])  state_d[i] = ST_DONE;
        ST_DONE: if (!req[i]) state_d[i] = ST_IDLE;
        default:              state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ack_d     = '0;
    err_d     = '0;
    dbg_state = '0;
    for (int i = 0; i < CORES; i++) begin
      ack_d[i] = (state_d[i] == ST_DONE);
      if (state_q[i] == ST_WAIT)      err_d[i] = svc[i] & svc_err[i];
      else if (state_d[i] == ST_DONE) err_d[i] = err[i];
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack    <= '0;
      err    <= '0;
      cap_op <= '0;
      armed  <= '0;
      for (int i = 0; i < CORES; i++) begin
        state_q[i] <= ST_IDLE;
        cap_id[i]  <= '0;
      end
    end else begin
      ack <= ack_d;
      err <= err_d;
      for (int i = 0; i < CORES; i++) begin
        state_q[i] <= state_d[i];
        armed[i]   <= (state_q[i] == ST_WAIT) && (state_d[i] == ST_WAIT);
        if (state_q[i] == ST_IDLE && req[i]) begin
          cap_op[i] <= op[i];
          cap_id[i] <= lock_id[i*LOCK_W +: LOCK_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_held <= '0;
      for (int k = 0; k < LOCKS; k++) begin
        owner_q[k] <= '0;
        ptr_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < LOCKS; k++) begin
        if (lock_release[k]) begin
          lock_held[k] <= 1'b0;
          owner_q[k]   <= '0;
        end else if (lock_grant[k]) begin
          lock_held[k] <= 1'b1;
          owner_q[k]   <= gnt_idx[k];
          ptr_q[k]     <= (gnt_idx[k] == CW'(CORES - 1)) ? '0 : gnt_idx[k] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hw_lock_ctrl.sv
// Directed bench for hw_lock_ctrl: drivers push {core, err, lock_held} into a
// queue, a negedge monitor pops the matching entry on every rising ack.
module tb_hw_lock_ctrl;

  localparam int CORES  = 4;
  localparam int LOCKS  = 8;
  localparam int LOCK_W = 4;
  localparam int W      = 13;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [CORES-1:0]        req, op;
  logic [CORES*LOCK_W-1:0] lock_id;
  logic [CORES-1:0]        ack, err;
  logic [LOCKS-1:0]        lock_held;
  logic [2*CORES-1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [CORES-1:0] ack_prev = '0;
  logic [W-1:0]     mon_e;
  int               mon_idx;

  hw_lock_ctrl #(.CORES(CORES), .LOCKS(LOCKS), .LOCK_W(LOCK_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .lock_id(lock_id),
    .ack(ack), .err(err), .lock_held(lock_held), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

  // op and lock_id must stay stable while req is held high
  logic [CORES-1:0]        req_p, op_p;
  logic [CORES*LOCK_W-1:0] id_p;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < CORES; i++) begin
        if (req[i] && req_p[i])
          assert (op[i] == op_p[i] && lock_id[i*LOCK_W +: LOCK_W] == id_p[i*LOCK_W +: LOCK_W])
            else $error("protocol violation on core %0d", i);
      end
    end
    req_p <= req;
    op_p  <= op;
    id_p  <= lock_id;
  end

  always @(negedge clk) begin
    for (int c = 0; c < CORES; c++) begin
      if (ack[c] && !ack_prev[c]) begin
        mon_idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          mon_e = exp_q[j];
          if (mon_idx < 0 && mon_e[12:9] == 4'(c)) mon_idx = j;
        end
        checks++;
        if (mon_idx < 0) begin
          errors++;
          $display("FAIL sb_core%0d: unexpected ack err=%0d held=%h, required no ack", c, err[c], lock_held);
        end else begin
          mon_e = exp_q[mon_idx];
          exp_q.delete(mon_idx);
          if (err[c] !== mon_e[8] || lock_held !== mon_e[7:0]) begin
            errors++;
            $display("FAIL sb_core%0d: err=%0d held=%h, required err=%0d held=%h",
                     c, err[c], lock_held, mon_e[8], mon_e[7:0]);
          end
        end
      end
    end
    ack_prev = ack;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic expect_ack(input int c, input logic e, input logic [7:0] held);
    exp_q.push_back({4'(c), e, held});
  endtask

  task automatic start_req(input int c, input logic o, input int id);
    op[c] = o;
    lock_id[c*LOCK_W +: LOCK_W] = LOCK_W'(id);
    req[c] = 1'b1;
  endtask

  task automatic wait_ack(input int c);
    int n;
    n = 0;
    while (!ack[c] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!ack[c]) begin
      checks++;
      errors++;
      $display("FAIL timeout_ack%0d: ack=0 after 30 cycles, required 1", c);
    end
  endtask

  task automatic drop_req(input int c);
    req[c] = 1'b0;
    @(negedge clk);
    check($sformatf("ack_fall%0d", c), 32'(ack[c]), 32'h0);
    check($sformatf("err_fall%0d", c), 32'(err[c]), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; req = '0; op = '0; lock_id = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack",  32'(ack), 32'h0);
    check("rst_err",  32'(err), 32'h0);
    check("rst_held", 32'(lock_held), 32'h0);
    check("rst_dbg",  32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: uncontended acquire / release, exact latency
    expect_ack(1, 1'b0, 8'h08);
    start_req(1, 1'b1, 3);
    @(negedge clk); check("t1_lat_e0", 32'(ack[1]), 32'h0);
    @(negedge clk); check("t1_lat_e1", 32'(ack[1]), 32'h0);
    @(negedge clk); check("t1_ack_e2", 32'(ack[1]), 32'h1);
    check("t1_err",  32'(err[1]), 32'h0);
    check("t1_held", 32'(lock_held), 32'h08);
    drop_req(1);
    expect_ack(1, 1'b0, 8'h00);
    start_req(1, 1'b0, 3);
    wait_ack(1);
    check("t1_rel_held", 32'(lock_held), 32'h0);
    drop_req(1);

    // 2: contention on lock 5 with round-robin
    do_reset();
    expect_ack(0, 1'b0, 8'h20);
    start_req(0, 1'b1, 5); start_req(2, 1'b1, 5); start_req(3, 1'b1, 5);
    wait_ack(0);
    check("t2_stall2", 32'(ack[2]), 32'h0);
    check("t2_stall3", 32'(ack[3]), 32'h0);
    drop_req(0);
    expect_ack(0, 1'b0, 8'h00);
    expect_ack(2, 1'b0, 8'h20);
    start_req(0, 1'b0, 5);
    wait_ack(0);
    check("t2_freed", 32'(lock_held[5]), 32'h0);
    check("t2_nobypass", 32'(ack[2]), 32'h0);
    @(negedge clk);
    check("t2_grant2", 32'(ack[2]), 32'h1);
    check("t2_not3",   32'(ack[3]), 32'h0);
    drop_req(0);
    expect_ack(0, 1'b0, 8'h20);
    start_req(0, 1'b1, 5);
    drop_req(2);
    expect_ack(2, 1'b0, 8'h00);
    expect_ack(3, 1'b0, 8'h20);
    start_req(2, 1'b0, 5);
    wait_ack(2);
    check("t2_nobypass3", 32'(ack[3]), 32'h0);
    @(negedge clk);
    check("t2_grant3", 32'(ack[3]), 32'h1);
    check("t2_core0_waits", 32'(ack[0]), 32'h0);
    drop_req(2);
    drop_req(3);
    expect_ack(3, 1'b0, 8'h00);
    start_req(3, 1'b0, 5);
    wait_ack(3);
    drop_req(3);
    wait_ack(0);
    check("t2_grant0_held", 32'(lock_held), 32'h20);
    drop_req(0);
    expect_ack(0, 1'b0, 8'h00);
    start_req(0, 1'b0, 5);
    wait_ack(0);
    drop_req(0);

    // 3: error responses
    expect_ack(0, 1'b0, 8'h10); start_req(0, 1'b1, 4); wait_ack(0); drop_req(0);
    expect_ack(2, 1'b1, 8'h10); start_req(2, 1'b0, 4); wait_ack(2);
    check("t3_rel_other_err", 32'(err[2]), 32'h1);
    check("t3_still_held", 32'(lock_held[4]), 32'h1);
    drop_req(2);
    expect_ack(1, 1'b1, 8'h10); start_req(1, 1'b1, 9); wait_ack(1);
    check("t3_range_err", 32'(err[1]), 32'h1);
    drop_req(1);
    expect_ack(0, 1'b1, 8'h10); start_req(0, 1'b1, 4); wait_ack(0);
    check("t3_reacq_err", 32'(err[0]), 32'h1);
    drop_req(0);
    expect_ack(3, 1'b1, 8'h10); start_req(3, 1'b0, 2); wait_ack(3); drop_req(3);
    expect_ack(0, 1'b0, 8'h00); start_req(0, 1'b0, 4); wait_ack(0); drop_req(0);

    // 4: independent locks granted in the same cycle
    expect_ack(0, 1'b0, 8'h06); expect_ack(1, 1'b0, 8'h06);
    start_req(0, 1'b1, 1); start_req(1, 1'b1, 2);
    wait_ack(0);
    check("t4_both_ack", 32'(ack[1]), 32'h1);
    check("t4_held", 32'(lock_held), 32'h06);
    drop_req(0); drop_req(1);
    expect_ack(0, 1'b0, 8'h00); expect_ack(1, 1'b0, 8'h00);
    start_req(0, 1'b0, 1); start_req(1, 1'b0, 2);
    wait_ack(0);
    check("t4_both_rel", 32'(ack[1]), 32'h1);
    drop_req(0); drop_req(1);

    // 5: req held after ack, then immediate re-raise
    expect_ack(3, 1'b0, 8'h80); start_req(3, 1'b1, 7); wait_ack(3);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d", n), 32'(ack[3]), 32'h1);
    end
    check("t5_held", 32'(lock_held), 32'h80);
    drop_req(3);
    expect_ack(3, 1'b0, 8'h00);
    start_req(3, 1'b0, 7);
    @(negedge clk); check("t5_re_e0", 32'(ack[3]), 32'h0);
    @(negedge clk); check("t5_re_e1", 32'(ack[3]), 32'h0);
    @(negedge clk); check("t5_re_e2", 32'(ack[3]), 32'h1);
    check("t5_re_held", 32'(lock_held), 32'h0);
    drop_req(3);

    // 6: asynchronous reset while locks are owned and a core waits
    expect_ack(0, 1'b0, 8'h03); expect_ack(1, 1'b0, 8'h03);
    start_req(0, 1'b1, 0); start_req(1, 1'b1, 1);
    wait_ack(0); drop_req(0); drop_req(1);
    start_req(2, 1'b1, 0);
    repeat (4) @(negedge clk);
    check("t6_stall", 32'(ack[2]), 32'h0);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    check("t6_rst_ack",  32'(ack), 32'h0);
    check("t6_rst_held", 32'(lock_held), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_ack(1, 1'b0, 8'h01); start_req(1, 1'b1, 0); wait_ack(1); drop_req(1);
    // ptr for lock 1 was 2 before reset; after reset core 0 must beat core 3
    expect_ack(0, 1'b0, 8'h03);
    start_req(0, 1'b1, 1); start_req(3, 1'b1, 1);
    wait_ack(0);
    check("t6_ptr_reset", 32'(ack[3]), 32'h0);
    drop_req(0);
    expect_ack(0, 1'b0, 8'h01); expect_ack(3, 1'b0, 8'h03);
    start_req(0, 1'b0, 1);
    wait_ack(0); wait_ack(3);
    drop_req(0); drop_req(3);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending: %0d expected acks never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
